// File: rtl/pipe_skid_stage.sv
// Pipeline register stage with an optional second (skid) entry so IN_READY can be
// registered and decoupled from OUT_READY. SKID=0 degrades to a single register.
module pipe_skid_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [1:0]        OCCUPANCY,
    output logic [15:0]       STALL_CNT
);

    localparam bit LP_SKID = (SKID != 0);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              r_rdy_en;
    logic [15:0]       r_stall_cnt;

    logic w_out_valid;
    logic w_in_ready;
    logic w_in_fire;
    logic w_out_fire;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = IN_VALID & w_in_ready;
    assign w_out_fire  = w_out_valid & OUT_READY;

    // r_rdy_en holds IN_READY low through reset and until the first edge after release.
    generate
        if (LP_SKID) begin : g_skid
            assign w_in_ready = r_rdy_en & (r_state != ST_TWO);
        end else begin : g_single
            assign w_in_ready = r_rdy_en & (~w_out_valid | OUT_READY);
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (FLUSH) begin
            // Main data is left as is; OUT_CTRL is masked by OUT_VALID.
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_state     <= ST_ONE;
                        r_main_data <= IN_DATA;
                        r_main_ctrl <= IN_CTRL;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_data <= IN_DATA;
                        r_main_ctrl <= IN_CTRL;
                    end else if (w_in_fire && LP_SKID) begin
                        r_state     <= ST_TWO;
                        r_skid_data <= IN_DATA;
                        r_skid_ctrl <= IN_CTRL;
                    end else if (w_out_fire) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        r_state     <= ST_ONE;
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !OUT_READY && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign IN_READY  = w_in_ready;
    assign OUT_VALID = w_out_valid;
    assign OUT_DATA  = r_main_data;
    assign OUT_CTRL  = w_out_valid ? r_main_ctrl : '0;
    assign OCCUPANCY = r_state;
    assign STALL_CNT = r_stall_cnt;

    a_no_fire_in_two : assert property (@(posedge CLK) disable iff (!RESET)
        !((r_state == ST_TWO) && w_in_fire));
    a_state_legal : assert property (@(posedge CLK) disable iff (!RESET)
        (r_state != 2'd3) && (LP_SKID || (r_state != ST_TWO)));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Drives a SKID=1 and a SKID=0 instance with the same stimulus and checks both
// against a queue-style model of held entries.
module tb_pipe_skid_stage;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [15:0] in_ctrl = '0;
    logic        out_ready = 1'b0;

    logic        o_rdy   [2];
    logic        o_vld   [2];
    logic [31:0] o_data  [2];
    logic [15:0] o_ctrl  [2];
    logic [1:0]  o_occ   [2];
    logic [15:0] o_stall [2];

    always #5 CLK = ~CLK;

    pipe_skid_stage #(.DATA_W(32), .CTRL_W(16), .SKID(1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(o_rdy[1]), .IN_DATA(in_data), .IN_CTRL(in_ctrl),
        .OUT_VALID(o_vld[1]), .OUT_READY(out_ready), .OUT_DATA(o_data[1]), .OUT_CTRL(o_ctrl[1]),
        .OCCUPANCY(o_occ[1]), .STALL_CNT(o_stall[1])
    );

    pipe_skid_stage #(.DATA_W(32), .CTRL_W(16), .SKID(0)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(o_rdy[0]), .IN_DATA(in_data), .IN_CTRL(in_ctrl),
        .OUT_VALID(o_vld[0]), .OUT_READY(out_ready), .OUT_DATA(o_data[0]), .OUT_CTRL(o_ctrl[0]),
        .OCCUPANCY(o_occ[0]), .STALL_CNT(o_stall[0])
    );

    int n_chk = 0;
    int n_err = 0;
    bit do_chk = 1'b1;

    // Model: per instance, an ordered list of held entries (capacity 2 or 1).
    logic [31:0] m_dat   [2][2];
    logic [15:0] m_ctl   [2][2];
    int          m_cnt   [2];
    logic [31:0] m_hold  [2];
    int          m_stall [2];
    bit          m_rdy;
    logic [31:0] seq = 32'h100;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_hold[k] = '0; m_stall[k] = 0;
        end
        m_rdy = 1'b0;
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic [15:0] c,
                        input logic ordy, input logic fl);
        bit e_rdy [2];
        bit f_in  [2];
        bit f_out [2];
        @(negedge CLK);
        in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
        #1;
        for (int k = 0; k < 2; k++) begin
            e_rdy[k] = m_rdy && ((k == 1) ? (m_cnt[k] < 2) : (m_cnt[k] == 0 || ordy));
            f_in[k]  = v && e_rdy[k];
            f_out[k] = (m_cnt[k] > 0) && ordy;
            if (do_chk) begin
                chk($sformatf("rdy%0d", k),   o_rdy[k],   e_rdy[k]);
                chk($sformatf("vld%0d", k),   o_vld[k],   m_cnt[k] > 0);
                chk($sformatf("occ%0d", k),   o_occ[k],   m_cnt[k]);
                chk($sformatf("data%0d", k),  o_data[k],  m_hold[k]);
                chk($sformatf("ctrl%0d", k),  o_ctrl[k],  (m_cnt[k] > 0) ? m_ctl[k][0] : 16'h0);
                chk($sformatf("stall%0d", k), o_stall[k], m_stall[k]);
            end
        end
        @(posedge CLK);
        for (int k = 0; k < 2; k++) begin
            if ((m_cnt[k] > 0) && !ordy && (m_stall[k] < 65535)) m_stall[k]++;
            if (fl) begin
                m_cnt[k] = 0;
            end else begin
                if (f_out[k]) begin
                    m_dat[k][0] = m_dat[k][1]; m_ctl[k][0] = m_ctl[k][1];
                    m_cnt[k]--;
                end
                if (f_in[k]) begin
                    m_dat[k][m_cnt[k]] = d; m_ctl[k][m_cnt[k]] = c;
                    m_cnt[k]++;
                end
            end
            if (m_cnt[k] > 0) m_hold[k] = m_dat[k][0];
        end
        m_rdy = 1'b1;
    endtask

    // Reset dropped and released between clock edges; outputs must clear without a clock.
    task automatic rst_pulse();
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        model_clear();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_vld%0d", k),   o_vld[k],   1'b0);
            chk($sformatf("rst_data%0d", k),  o_data[k],  32'h0);
            chk($sformatf("rst_ctrl%0d", k),  o_ctrl[k],  16'h0);
            chk($sformatf("rst_occ%0d", k),   o_occ[k],   2'd0);
            chk($sformatf("rst_stall%0d", k), o_stall[k], 16'h0);
            chk($sformatf("rst_rdy%0d", k),   o_rdy[k],   1'b0);
        end
        in_valid = 1'b0; flush = 1'b0;
        #1 RESET = 1'b1;
        @(posedge CLK);
        m_rdy = 1'b1;
    endtask

    task automatic send(input logic ordy);
        seq++;
        step(1'b1, seq, seq[15:0] ^ 16'hA5A5, ordy, 1'b0);
    endtask

    task automatic rnd_run(input int n);
        for (int i = 0; i < n; i++) begin
            seq++;
            step(($urandom % 4) != 0, seq, 16'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0);
        end
    endtask

    initial begin
        model_clear();
        rst_pulse();

        // Streaming 1,2,3 with OUT_READY high.
        step(1'b1, 32'd1, 16'h0011, 1'b1, 1'b0);
        step(1'b1, 32'd2, 16'h0022, 1'b1, 1'b0);
        step(1'b1, 32'd3, 16'h0033, 1'b1, 1'b0);
        step(1'b0, 32'd0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 16'h0, 1'b1, 1'b0);

        // Back-pressure: A then B with OUT_READY low, then drain.
        step(1'b1, 32'hAAAA, 16'h0A0A, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB, 16'h0B0B, 1'b0, 1'b0);
        step(1'b1, 32'hCCCC, 16'h0C0C, 1'b0, 1'b0);
        chk("bp_occ", o_occ[1], 2'd2);
        chk("bp_data", o_data[1], 32'hAAAA);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 16'h0, 1'b1, 1'b0);

        // Flush while full, with an entry offered in the same cycle.
        send(1'b0);
        send(1'b0);
        step(1'b1, 32'hDEAD, 16'hFFFF, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 16'h0, 1'b1, 1'b0);

        rnd_run(1500);

        // Mid-operation async reset while full.
        send(1'b0);
        send(1'b0);
        rst_pulse();
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 16'h0, 1'b1, 1'b0);
        rnd_run(200);

        // Stall counter saturation.
        send(1'b0);
        do_chk = 1'b0;
        for (int i = 0; i < 70000; i++) step(1'b0, 32'd0, 16'h0, 1'b0, 1'b0);
        do_chk = 1'b1;
        chk("sat1", o_stall[1], 16'hFFFF);
        chk("sat0", o_stall[0], 16'hFFFF);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 16'h0, 1'b0, 1'b0);
        rnd_run(300);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
